uart_tx_q: RTL and testbench
============================

# uart_tx_q

Parametrised UART transmitter with an integrated transmit FIFO, configurable data width, parity mode and stop-bit count. It replaces the fixed 8N1 transmit path in the UART peripheral. The bus-side register block (APB/AHB/Avalon/simple interface) pushes bytes through a valid/ready port. The block serialises them, LSB first, onto `tx` at a programmable baud divisor.

## Interface
- `DW`, 8, data bits per frame; legal range 5..9.
- `FIFO_D`, 8, FIFO depth in words; power of two, ≥ 2.
- `BR_W`, 16, width of the baud divisor.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_en` in 1: transmitter enable.
- `cfg_dfv` in BR_W: baud divisor; bit period = `cfg_dfv`+1 clocks.
- `cfg_par` in 2: 00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2` in 1: 0 = one stop bit, 1 = two stop bits.
- `wr_valid` in 1: write request.
- `wr_data` in DW: word to transmit.
- `wr_ready` out 1: FIFO can accept; equals !`fifo_full`.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: FSM not in IDLE.
- `tx_done` out 1: one-cycle pulse at the end of each frame.
- `fifo_cnt` out $clog2(FIFO_D)+1: words stored.
- `fifo_full`, `fifo_empty` out 1: FIFO status.

## Operation
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_cnt`=0, `fifo_empty`=1, `fifo_full`=0, `wr_ready`=1.
- Reset flushes the FIFO and returns the FSM to IDLE in all cases. A frame in progress is abandoned. `tx` is 1 from the first cycle after the reset edge.
- **Push:** a word is written on an edge with `wr_valid && wr_ready`.
- **Full FIFO:** writes are refused when `fifo_full` is set, even if a pop occurs on the same edge.
- **Write order:** writes are accepted regardless of `cfg_en`. Order is strict FIFO.
- **Push and pop together:** on the same edge, `fifo_cnt` is unchanged.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
- **IDLE:**
  - Leaves IDLE only when `cfg_en && !fifo_empty`.
  - On that edge it pops the head word into the shift register and latches `cfg_dfv`, `cfg_par` and `cfg_stop2` into frame-local copies.
  - It then moves to START.
- **Configuration changes:** changes to `cfg_*` during a frame have no effect until the next frame start.
- **State sequence:**
  - START: 1 bit, `tx`=0. Goes to DATA.
  - DATA: DW bits, LSB first. Goes to PAR if parity is enabled, otherwise to STOP.
  - PAR: 1 bit. Goes to STOP.
  - STOP: 1 or 2 bits, `tx`=1.
- **Parity bit:** even = XOR of the data bits; odd = inverted XOR.
- **End of STOP:**
  - `tx_done` pulses for one cycle.
  - If `cfg_en && !fifo_empty`, the FSM pops the next word and enters START directly, with no idle bit between frames.
  - Otherwise it returns to IDLE.
- **Disable mid-frame:** deasserting `cfg_en` during a frame lets the current frame complete, then the FSM holds in IDLE.
- **Bit timing:** a down-counter reloads with the latched divisor at each bit start. The bit ends when the counter reaches 0. With `cfg_dfv`=0, each bit lasts 1 clock.
- **Bit index:** the counter wraps at DW−1 (DATA) and at the stop count (STOP).

## Timing
- **Write to start bit:** a word written at edge N into an empty FIFO while IDLE and enabled is popped at edge N+1. `tx` goes 0 after edge N+1, giving 2-edge latency.
- **Frame length:** (1 + DW + P + S)·(`cfg_dfv`+1) clocks, where P ∈ {0,1} is the parity bit and S ∈ {1,2} is the stop-bit count.
- **`tx_done`:** high for the cycle following the final edge of the last stop bit. This is the same edge on which the next START begins in back-to-back operation.
- **`busy`:** high from the START edge through the end of the last frame. In a back-to-back stream it never drops between frames.
- **Status timing:** `fifo_cnt`, `fifo_full` and `fifo_empty` are registered and update on the push/pop edge.

## Test plan
- **Reset:** hold `rst` for 3 cycles → `tx`=1, `wr_ready`=1, `fifo_empty`=1, `fifo_cnt`=0, `busy`=0, `tx_done`=0.
- **8N1 frame:** DW=8, `cfg_dfv`=3, `cfg_par`=00, `cfg_stop2`=0, write 0xA5 →
  - `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks (40 clocks total).
  - One `tx_done` pulse at frame end, then `busy`=0.
- **Parity and stop bits:** `cfg_dfv`=1, write 0x07 →
  - `cfg_par`=01: parity bit is 1.
  - `cfg_par`=10: parity bit is 0.
  - `cfg_stop2`=1 gives a 2-bit stop (4 clocks high) before the next start.
- **FIFO full and back-to-back:** FIFO_D=4, `cfg_en`=0, write 0x11,0x22,0x33,0x44,0x55 →
  - First 4 are accepted; `wr_ready`=0, `fifo_full`=1, `fifo_cnt`=4; 0x55 is not accepted.
  - Set `cfg_en`=1 → 4 frames in order 0x11..0x44 with no idle bit between them, `busy` held high, and 4 `tx_done` pulses.
- **Reset mid-frame:** assert `rst` during data bit 3 with 2 words queued →
  - `tx`=1 the following cycle, `fifo_cnt`=0, `busy`=0.
  - A subsequent write of 0x3C transmits a correct frame.
- **Config change mid-frame:** change `cfg_dfv` from 3 to 7 during the DATA state →
  - The current frame keeps 4 clocks per bit.
  - The next queued frame uses 8 clocks per bit.

Source files
------------

// File: rtl/uart_tx_q_if.sv
// Write port of the UART transmitter: valid/ready push into the transmit FIFO.
interface uart_tx_q_if #(
  parameter int unsigned DW = 8
) ();

  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;

  // Bus-side register block drives words in.
  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  // Transmitter accepts words.
  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/uart_tx_q.sv
// UART transmitter with integrated transmit FIFO, configurable data width,
// parity mode and stop-bit count. Frames are serialised LSB first onto tx.
module uart_tx_q #(
  parameter int unsigned DW     = 8,
  parameter int unsigned FIFO_D = 8,
  parameter int unsigned BR_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_en,
  input  logic [BR_W-1:0]           cfg_dfv,
  input  logic [1:0]                cfg_par,
  input  logic                      cfg_stop2,
  uart_tx_q_if.slave                wr_if,
  output logic                      tx,
  output logic                      busy,
  output logic                      tx_done,
  output logic [$clog2(FIFO_D):0]   fifo_cnt,
  output logic                      fifo_full,
  output logic                      fifo_empty
);

  localparam int unsigned PtrW = $clog2(FIFO_D);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BitW = 4;
  localparam logic [BitW-1:0] LastData = BitW'(DW - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } state_e;

  // FIFO storage and pointers.
  logic [DW-1:0]   mem_q [FIFO_D];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push, pop;
  logic [DW-1:0]   head;

  // Frame state and frame-local configuration copies.
  state_e          state_q, state_d;
  logic [BR_W-1:0] baud_q, baud_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [BR_W-1:0] dfv_q, dfv_d;
  logic            par_en_q, par_en_d;
  logic            par_bit_q, par_bit_d;
  logic            stop2_q, stop2_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic            can_start;
  logic            bit_end;
  logic            load;

  assign fifo_full      = (cnt_q == CntW'(FIFO_D));
  assign fifo_empty     = (cnt_q == '0);
  assign fifo_cnt       = cnt_q;
  assign wr_if.wr_ready = !fifo_full;

  // A full FIFO refuses writes even when a pop frees a slot on the same edge.
  assign push = wr_if.wr_valid && !fifo_full;
  assign head = mem_q[rd_ptr_q];

  assign tx      = tx_q;
  assign busy    = (state_q != StIdle);
  assign tx_done = done_q;

  assign can_start = cfg_en && !fifo_empty;
  assign bit_end   = (baud_q == '0);

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
  end

  // Transmit FSM: bit timing, serialisation and frame-to-frame chaining.
  always_comb begin
    state_d   = state_q;
    baud_d    = bit_end ? dfv_q : baud_q - BR_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    dfv_d     = dfv_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d = baud_q;
        tx_d   = 1'b1;
        if (can_start) begin
          load = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == LastData) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = StPar;
              tx_d    = par_bit_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StPar: begin
        if (bit_end) begin
          state_d = StStop;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == BitW'(stop2_q)) begin
            done_d = 1'b1;
            // Chain straight into the next START with no idle bit.
            if (can_start) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: pop the head word and freeze the configuration for this frame.
    if (load) begin
      state_d   = StStart;
      shift_d   = head;
      dfv_d     = cfg_dfv;
      baud_d    = cfg_dfv;
      par_en_d  = cfg_par[0] ^ cfg_par[1];
      par_bit_d = (^head) ^ (cfg_par == 2'b10);
      stop2_d   = cfg_stop2;
      bit_d     = '0;
      tx_d      = 1'b0;
    end
  end

  assign pop = load;

  // FIFO storage write; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_if.wr_data;
    end
  end

  // State registers with synchronous reset; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      dfv_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      dfv_q     <= dfv_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_q.sv
// Directed testbench for uart_tx_q (DW=8, FIFO_D=4, BR_W=16).
module tb_uart_tx_q;

  logic        clk;
  logic        rst;
  logic        cfg_en;
  logic [15:0] cfg_dfv;
  logic [1:0]  cfg_par;
  logic        cfg_stop2;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [2:0]  fifo_cnt;
  logic        fifo_full;
  logic        fifo_empty;

  int n_vec;
  int n_err;

  uart_tx_q_if #(.DW(8)) wr_if ();

  uart_tx_q #(
    .DW     (8),
    .FIFO_D (4),
    .BR_W   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_en     (cfg_en),
    .cfg_dfv    (cfg_dfv),
    .cfg_par    (cfg_par),
    .cfg_stop2  (cfg_stop2),
    .wr_if      (wr_if),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_cnt   (fifo_cnt),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle write, starting and ending at a falling edge.
  task automatic push(input logic [7:0] d);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
  endtask

  // Wait (bounded) for the start bit; waited = falling edges taken, -1 on timeout.
  task automatic wait_start(output int waited);
    waited = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        waited = i;
        break;
      end
    end
  endtask

  // Sample tx for n cycles starting with the current cycle.
  task automatic capture(input int n, input int chg_at, input logic [15:0] chg_val,
                         output logic [511:0] v, output int dones, output int busy_low);
    v = '0;
    dones = 0;
    busy_low = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i == chg_at) cfg_dfv = chg_val;
      v[i] = tx;
      if (tx_done === 1'b1) dones++;
      if (busy !== 1'b1) busy_low++;
    end
  endtask

  // Expand a transmit-order bit list (bit 0 first) into per-clock samples.
  task automatic expand(input logic [63:0] seq, input int nb, input int per,
                        output logic [511:0] v);
    v = '0;
    for (int b = 0; b < nb; b++)
      for (int p = 0; p < per; p++) v[b*per+p] = seq[b];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b exp 1", tx); end
    n_vec++; if (wr_if.wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b exp 1", wr_if.wr_ready); end
    n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b exp 1", fifo_empty); end
    n_vec++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b exp 0", fifo_full); end
    n_vec++; if (fifo_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d exp 0", fifo_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_tx_done: got %b exp 0", tx_done); end
  endtask

  task automatic test_8n1();
    logic [511:0] got, exp;
    int w, d, bl;
    cfg_en = 1'b1; cfg_dfv = 16'd3; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    push(8'hA5);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL 8n1_pre_start_tx: got %b exp 1", tx); end
    n_vec++; if (fifo_cnt !== 3'd1) begin n_err++; $display("FAIL 8n1_cnt_after_push: got %0d exp 1", fifo_cnt); end
    wait_start(w);
    n_vec++; if (w !== 1) begin n_err++; $display("FAIL 8n1_latency: got %0d exp 1", w); end
    n_vec++; if (fifo_cnt !== 3'd0) begin n_err++; $display("FAIL 8n1_cnt_after_pop: got %0d exp 0", fifo_cnt); end
    capture(40, -1, 16'd0, got, d, bl);
    expand({1'b1, 8'hA5, 1'b0}, 10, 4, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL 8n1_frame: got %h exp %h", got, exp); end
    n_vec++; if (d !== 0) begin n_err++; $display("FAIL 8n1_early_done: got %0d exp 0", d); end
    n_vec++; if (bl !== 0) begin n_err++; $display("FAIL 8n1_busy_in_frame: got %0d low cycles exp 0", bl); end
    @(negedge clk);
    n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL 8n1_done_pulse: got %b exp 1", tx_done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL 8n1_busy_end: got %b exp 0", busy); end
    @(negedge clk);
    n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL 8n1_done_width: got %b exp 0", tx_done); end
  endtask

  task automatic test_parity();
    logic [511:0] got, exp;
    int w, d, bl;
    // Even parity, one stop bit: 0x07 has three ones so the parity bit is 1.
    cfg_en = 1'b0; cfg_dfv = 16'd1; cfg_par = 2'b01; cfg_stop2 = 1'b0;
    push(8'h07);
    cfg_en = 1'b1;
    wait_start(w);
    n_vec++; if (w !== 1) begin n_err++; $display("FAIL even_latency: got %0d exp 1", w); end
    capture(22, -1, 16'd0, got, d, bl);
    expand({1'b1, 1'b1, 8'h07, 1'b0}, 11, 2, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL even_frame: got %h exp %h", got, exp); end
    @(negedge clk);
    n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL even_done: got %b exp 1", tx_done); end
    // Odd parity, two stop bits, two frames chained back to back.
    cfg_en = 1'b0; cfg_par = 2'b10; cfg_stop2 = 1'b1;
    push(8'h07);
    push(8'h07);
    cfg_en = 1'b1;
    wait_start(w);
    n_vec++; if (w !== 1) begin n_err++; $display("FAIL odd_latency: got %0d exp 1", w); end
    capture(24, -1, 16'd0, got, d, bl);
    expand({2'b11, 1'b0, 8'h07, 1'b0}, 12, 2, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL odd_frame1: got %h exp %h", got, exp); end
    @(negedge clk);
    n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL odd_next_start: got %b exp 0", tx); end
    n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL odd_done1: got %b exp 1", tx_done); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL odd_busy_between: got %b exp 1", busy); end
    capture(24, -1, 16'd0, got, d, bl);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL odd_frame2: got %h exp %h", got, exp); end
    @(negedge clk);
    n_vec++; if (tx_done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL odd_end: got done=%b busy=%b exp done=1 busy=0", tx_done, busy);
    end
  endtask

  task automatic test_fifo_full_b2b();
    logic [511:0] got, exp;
    int d, bl;
    cfg_en = 1'b0; cfg_dfv = 16'd1; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    n_vec++; if (fifo_cnt !== 3'd4) begin n_err++; $display("FAIL full_cnt: got %0d exp 4", fifo_cnt); end
    n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b exp 1", fifo_full); end
    n_vec++; if (wr_if.wr_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b exp 0", wr_if.wr_ready); end
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'h55;
    @(negedge clk);
    n_vec++; if (fifo_cnt !== 3'd4) begin n_err++; $display("FAIL full_refuse: got %0d exp 4", fifo_cnt); end
    // Pop and refused push on the same edge.
    cfg_en = 1'b1;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    n_vec++; if (fifo_cnt !== 3'd3) begin n_err++; $display("FAIL full_pop_refuse: got %0d exp 3", fifo_cnt); end
    n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL b2b_start: got %b exp 0", tx); end
    capture(80, -1, 16'd0, got, d, bl);
    expand({1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0},
           40, 2, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL b2b_frames: got %h exp %h", got, exp); end
    n_vec++; if (d !== 3) begin n_err++; $display("FAIL b2b_done_count: got %0d exp 3", d); end
    n_vec++; if (bl !== 0) begin n_err++; $display("FAIL b2b_busy: got %0d low cycles exp 0", bl); end
    @(negedge clk);
    n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL b2b_last_done: got %b exp 1", tx_done); end
    n_vec++; if (busy !== 1'b0 || fifo_empty !== 1'b1) begin
      n_err++; $display("FAIL b2b_end: got busy=%b empty=%b exp busy=0 empty=1", busy, fifo_empty);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [511:0] got, exp;
    int w, d, bl;
    cfg_en = 1'b0; cfg_dfv = 16'd3; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    cfg_en = 1'b1;
    wait_start(w);
    n_vec++; if (w !== 1) begin n_err++; $display("FAIL rmf_latency: got %0d exp 1", w); end
    repeat (17) @(negedge clk);
    // Now inside data bit 3 of 0xA1, which is 0.
    n_vec++; if (tx !== 1'b0 || fifo_cnt !== 3'd2) begin
      n_err++; $display("FAIL rmf_pre: got tx=%b cnt=%0d exp tx=0 cnt=2", tx, fifo_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL rmf_tx: got %b exp 1", tx); end
    n_vec++; if (fifo_cnt !== 3'd0) begin n_err++; $display("FAIL rmf_cnt: got %0d exp 0", fifo_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmf_busy: got %b exp 0", busy); end
    repeat (5) @(negedge clk);
    n_vec++; if (tx !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL rmf_quiet: got tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
    push(8'h3C);
    wait_start(w);
    n_vec++; if (w !== 1) begin n_err++; $display("FAIL rmf_post_latency: got %0d exp 1", w); end
    capture(40, -1, 16'd0, got, d, bl);
    expand({1'b1, 8'h3C, 1'b0}, 10, 4, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL rmf_post_frame: got %h exp %h", got, exp); end
    @(negedge clk);
    n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL rmf_post_done: got %b exp 1", tx_done); end
  endtask

  task automatic test_cfg_change();
    logic [511:0] got, exp;
    int w, d, bl;
    cfg_en = 1'b0; cfg_dfv = 16'd3; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    push(8'h5A);
    push(8'hC3);
    cfg_en = 1'b1;
    wait_start(w);
    n_vec++; if (w !== 1) begin n_err++; $display("FAIL cfg_latency: got %0d exp 1", w); end
    // Divisor changes to 7 during data bit 1 of the first frame.
    capture(40, 10, 16'd7, got, d, bl);
    expand({1'b1, 8'h5A, 1'b0}, 10, 4, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL cfg_frame1: got %h exp %h", got, exp); end
    @(negedge clk);
    capture(80, -1, 16'd0, got, d, bl);
    expand({1'b1, 8'hC3, 1'b0}, 10, 8, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL cfg_frame2: got %h exp %h", got, exp); end
    n_vec++; if (d !== 1) begin n_err++; $display("FAIL cfg_done_count: got %0d exp 1", d); end
    n_vec++; if (bl !== 0) begin n_err++; $display("FAIL cfg_busy: got %0d low cycles exp 0", bl); end
    @(negedge clk);
    n_vec++; if (tx_done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL cfg_end: got done=%b busy=%b exp done=1 busy=0", tx_done, busy);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    cfg_en = 1'b0;
    cfg_dfv = 16'd0;
    cfg_par = 2'b00;
    cfg_stop2 = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data = 8'h00;
    test_reset();
    test_8n1();
    test_parity();
    test_fifo_full_b2b();
    test_reset_mid_frame();
    test_cfg_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
